prog_instr_mem: RTL and testbench
=================================

Name: prog_instr_mem

Overview:
Parametrised instruction memory for the single-cycle RISC-V core. It replaces a hard-coded program image with a run-time program-load stream port.
- Adds byte-to-word address translation, alignment and range fault reporting, and a registered fetch port.
- After reset, a clear sweep fills memory with a NOP. The memory then sits between the PC register and the decoder.

Parameters:
XLEN, 32, instruction/data word width in bits
DEPTH, 64, number of words (power of two, >= 4)
ADDR_W, 32, byte-address width of fetch and load addresses
NOP_WORD, 32'h00000013, clear value and fault substitute (addi x0,x0,0)

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
fetch_req  input  1  fetch request this cycle
fetch_addr  input  ADDR_W  byte address of instruction
fetch_valid  output  1  fetch_instr/fetch_fault valid (one cycle after an accepted fetch_req)
fetch_instr  output  XLEN  fetched instruction
fetch_fault  output  2  bit0 misaligned, bit1 out-of-range
busy  output  1  high in CLEAR or LOAD; fetches are refused
load_start  input  1  pulse: begin load at load_base
load_base  input  ADDR_W  byte address of first loaded word
load_valid  input  1  load_data valid
load_data  input  XLEN  word to write
load_last  input  1  final word of the load stream
load_ready  output  1  block accepts load_data
load_done  output  1  one-cycle pulse when the last word is written
load_err  output  1  sticky: misaligned base or write past DEPTH; cleared by load_start or reset

Behaviour:
- Index: IW = log2(DEPTH); word index = addr[IW+1:2].
- Misaligned: addr[1:0] != 0. Out-of-range: addr >= DEPTH*4.
- Reset (async): state is CLEAR and the clear pointer is 0. All outputs are 0 except busy=1. load_err=0.
- States:
  - CLEAR: writes NOP_WORD to word[ptr] and increments ptr each cycle. After writing word DEPTH-1 it moves to IDLE. Takes exactly DEPTH cycles after reset release.
  - IDLE: busy=0, load_ready=0.
    - fetch_req=1 registers the read. The next cycle gives fetch_valid=1 with fetch_instr=word[index].
    - On any fault, fetch_instr=NOP_WORD and fetch_fault is set; both fault bits can be set together.
    - fetch_req=0 gives fetch_valid=0 next cycle, and fetch_instr holds its last value.
    - load_start=1 moves to LOAD: write pointer = index(load_base), load_err cleared.
    - If load_base is misaligned or out-of-range: load_err=1 and the pointer is still taken from the index bits. Writes are still performed (err only flags).
    - load_start has priority over a simultaneous fetch_req: the fetch is refused and fetch_valid=0 next cycle.
  - LOAD: busy=1, load_ready=1.
    - Each cycle with load_valid=1, word[ptr]=load_data and ptr increments.
    - If ptr wraps past DEPTH-1, the word is dropped (not written), load_err=1, and wrapping is suppressed. The following words are also dropped until load_last.
    - load_valid with load_last=1 writes or drops that word, pulses load_done on the same clock edge's next cycle, and returns to IDLE.
    - load_start during LOAD is ignored.
- fetch_req in CLEAR/LOAD: refused, fetch_valid=0 next cycle, memory not read.
- Read-after-write: a fetch in the first IDLE cycle after LOAD returns the newly written data.
- Reset mid-LOAD or mid-CLEAR: returns to CLEAR immediately and restarts the sweep from 0. Partially loaded content is overwritten.

Optional Feature:
- Macro IMEM_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit computed on write. NOP_WORD parity is computed during CLEAR.
  - A fetch recomputes parity. On mismatch, fetch_fault bit2 = 1 (fetch_fault becomes 3 bits wide) and fetch_instr = NOP_WORD.
  - Adds test-only input parity_flip (1 bit): when high during a LOAD write, the stored parity is inverted.
- When undefined: no parity storage, no parity_flip port, fetch_fault is 2 bits.

Test Plan:
- Reset, release, wait: busy=1 for exactly 64 cycles. Then fetch addr 0x10 -> fetch_valid=1, fetch_instr=32'h00000013, fault=0.
- load_start base 0x04, stream 32'h00948663, 32'h0000_0033 (last) -> load_done pulse, load_err=0. Fetch 0x04 -> 32'h00948663; fetch 0x08 -> 32'h00000033.
- Fetch 0x06 -> fault=2'b01, instr=NOP. Fetch 0x100 (DEPTH=64) -> fault=2'b10, instr=NOP.
- load_start base 0xF8, stream 4 words (last on 4th) -> words 62,63 written, words 3-4 dropped, load_err=1. word[0] still NOP.
- fetch_req while LOAD active -> fetch_valid=0. Assert reset mid-LOAD -> busy=1 for 64 cycles, word[1] reads NOP after.
- (IMEM_PARITY_EN) load word with parity_flip=1 at base 0 -> fetch 0x00 gives fault bit2=1, instr=NOP.

Source files
------------

// File: rtl/prog_instr_mem.sv
`default_nettype none
// prog_instr_mem: instruction memory with power-up NOP sweep, streaming program load and registered fetch.
// Optional macro IMEM_PARITY_EN adds per-word even parity, a third fetch_fault bit and the parity_flip input.
module prog_instr_mem #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 64,
    parameter int              ADDR_W   = 32,
    parameter logic [XLEN-1:0] NOP_WORD = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [XLEN-1:0]   fetch_instr,
`ifdef IMEM_PARITY_EN
    output logic [2:0]        fetch_fault,
    input  logic              parity_flip,
`else
    output logic [1:0]        fetch_fault,
`endif
    output logic              busy,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic              load_valid,
    input  logic [XLEN-1:0]   load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_err
);

    localparam int IW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
    localparam int FW = 3;
`else
    localparam int FW = 2;
`endif
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH * 4);

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            full_q, full_d;
    logic            load_err_q, load_err_d;
    logic            load_done_q, load_done_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic [XLEN-1:0] fetch_instr_q, fetch_instr_d;
    logic [FW-1:0]   fetch_fault_q, fetch_fault_d;

    logic [XLEN-1:0] mem_q [DEPTH];
`ifdef IMEM_PARITY_EN
    logic [DEPTH-1:0] par_q;
    logic             w_wpar;
    logic             w_par_bad;
`endif

    logic            w_we;
    logic [IW-1:0]   w_waddr;
    logic [XLEN-1:0] w_wdata;
    logic [IW-1:0]   w_fetch_idx;
    logic            w_fetch_mis, w_fetch_oor, w_fetch_go;
    logic            w_base_mis, w_base_oor;

    assign w_fetch_idx = fetch_addr[IW+1:2];
    assign w_fetch_mis = |fetch_addr[1:0];
    assign w_fetch_oor = (fetch_addr >= LIMIT);
    assign w_base_mis  = |load_base[1:0];
    assign w_base_oor  = (load_base >= LIMIT);
    // load_start wins over a same-cycle fetch
    assign w_fetch_go  = (state_q == S_IDLE) && fetch_req && !load_start;
`ifdef IMEM_PARITY_EN
    assign w_par_bad   = (^mem_q[w_fetch_idx]) != par_q[w_fetch_idx];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: if (ptr_q == IW'(DEPTH - 1)) state_d = S_IDLE;
            S_IDLE:  if (load_start) state_d = S_LOAD;
            S_LOAD:  if (load_valid && load_last) state_d = S_IDLE;
            default: state_d = S_CLEAR;
        endcase
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        load_ready = (state_q == S_LOAD);
    end

    always_comb begin
        ptr_d         = ptr_q;
        full_d        = full_q;
        load_err_d    = load_err_q;
        load_done_d   = 1'b0;
        fetch_valid_d = w_fetch_go;
        fetch_instr_d = fetch_instr_q;
        fetch_fault_d = fetch_fault_q;
        w_we          = 1'b0;
        w_waddr       = ptr_q;
        w_wdata       = NOP_WORD;
`ifdef IMEM_PARITY_EN
        w_wpar        = ^NOP_WORD;
`endif
        case (state_q)
            S_CLEAR: begin
                w_we  = 1'b1;
                ptr_d = ptr_q + 1'b1;
            end
            S_IDLE: begin
                if (load_start) begin
                    ptr_d      = load_base[IW+1:2];
                    full_d     = 1'b0;
                    load_err_d = w_base_mis | w_base_oor;
                end
            end
            S_LOAD: begin
                if (load_valid) begin
                    // once the last word slot is written, further words are dropped, not wrapped
                    if (full_q) begin
                        load_err_d = 1'b1;
                    end else begin
                        w_we    = 1'b1;
                        w_wdata = load_data;
`ifdef IMEM_PARITY_EN
                        w_wpar  = (^load_data) ^ parity_flip;
`endif
                        ptr_d   = ptr_q + 1'b1;
                        if (ptr_q == IW'(DEPTH - 1)) full_d = 1'b1;
                    end
                    if (load_last) load_done_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (w_fetch_go) begin
`ifdef IMEM_PARITY_EN
            fetch_fault_d = {w_par_bad, w_fetch_oor, w_fetch_mis};
`else
            fetch_fault_d = {w_fetch_oor, w_fetch_mis};
`endif
            fetch_instr_d = (|fetch_fault_d) ? NOP_WORD : mem_q[w_fetch_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q         <= '0;
            full_q        <= 1'b0;
            load_err_q    <= 1'b0;
            load_done_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_instr_q <= '0;
            fetch_fault_q <= '0;
        end else begin
            ptr_q         <= ptr_d;
            full_q        <= full_d;
            load_err_q    <= load_err_d;
            load_done_q   <= load_done_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_instr_q <= fetch_instr_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    // storage is not reset; the CLEAR sweep initialises it
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem_q[w_waddr] <= w_wdata;
`ifdef IMEM_PARITY_EN
            par_q[w_waddr] <= w_wpar;
`endif
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_instr = fetch_instr_q;
    assign fetch_fault = fetch_fault_q;
    assign load_done   = load_done_q;
    assign load_err    = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_instr_mem.sv
`default_nettype none
// tb_prog_instr_mem: directed stimulus with literal expectations plus a behavioural model compared every cycle.
module tb_prog_instr_mem;

    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h00000013;
`ifdef IMEM_PARITY_EN
    localparam int FW = 3;
`else
    localparam int FW = 2;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          fetch_req = 1'b0;
    logic [31:0]   fetch_addr = '0;
    logic          load_start = 1'b0;
    logic [31:0]   load_base = '0;
    logic          load_valid = 1'b0;
    logic [31:0]   load_data = '0;
    logic          load_last = 1'b0;
    logic          parity_flip = 1'b0;
    logic          fetch_valid, busy, load_ready, load_done, load_err;
    logic [31:0]   fetch_instr;
    logic [FW-1:0] fetch_fault;

    int n_checks = 0;
    int n_errors = 0;
    logic cmp_en = 1'b0;

    prog_instr_mem dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_fault (fetch_fault),
`ifdef IMEM_PARITY_EN
        .parity_flip (parity_flip),
`endif
        .busy        (busy),
        .load_start  (load_start),
        .load_base   (load_base),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 = clearing, 1 = idle, 2 = loading; m_cnt is an unbounded word counter.
    int            m_mode = 0;
    int            m_cnt  = 0;
    logic [31:0]   m_mem  [DEPTH];
    logic          m_pbad [DEPTH];
    logic          e_valid = 1'b0, e_done = 1'b0, e_err = 1'b0;
    logic [31:0]   e_instr = '0;
    logic [FW-1:0] e_fault = '0;

    task automatic model_step();
        logic [2:0] f;
        int         idx;
        if (reset) begin
            m_mode = 0; m_cnt = 0;
            e_valid = 1'b0; e_done = 1'b0; e_err = 1'b0; e_instr = '0; e_fault = '0;
        end else begin
            e_valid = 1'b0;
            e_done  = 1'b0;
            if (m_mode == 0) begin
                m_mem[m_cnt] = NOP;
                m_pbad[m_cnt] = 1'b0;
                m_cnt++;
                if (m_cnt == DEPTH) m_mode = 1;
            end else if (m_mode == 1) begin
                if (load_start) begin
                    m_mode = 2;
                    m_cnt  = int'(load_base[7:2]);
                    e_err  = (load_base[1:0] != 2'b00) || (load_base >= 32'(DEPTH * 4));
                end else if (fetch_req) begin
                    idx     = int'(fetch_addr[7:2]);
                    f       = {m_pbad[idx], fetch_addr >= 32'(DEPTH * 4), fetch_addr[1:0] != 2'b00};
                    e_valid = 1'b1;
                    e_fault = f[FW-1:0];
                    e_instr = (f[FW-1:0] != '0) ? NOP : m_mem[idx];
                end
            end else begin
                if (load_valid) begin
                    if (m_cnt < DEPTH) begin
                        m_mem[m_cnt]  = load_data;
                        m_pbad[m_cnt] = parity_flip;
                        m_cnt++;
                    end else begin
                        e_err = 1'b1;
                    end
                    if (load_last) begin
                        e_done = 1'b1;
                        m_mode = 1;
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("cyc_valid", 32'(fetch_valid), 32'(e_valid));
            chk("cyc_instr", fetch_instr, e_instr);
            chk("cyc_fault", 32'(fetch_fault), 32'(e_fault));
            chk("cyc_busy", 32'(busy), 32'(m_mode != 1));
            chk("cyc_ready", 32'(load_ready), 32'(m_mode == 2));
            chk("cyc_done", 32'(load_done), 32'(e_done));
            chk("cyc_err", 32'(load_err), 32'(e_err));
        end
    end

    task automatic wait_clear(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            if (busy) n++;
        end while (busy && n < 200);
        chk(name, n, 64);
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] ei, input logic [FW-1:0] ef,
                            input string name);
        @(posedge clk); #1 fetch_req = 1'b1; fetch_addr = a;
        @(posedge clk); #1 fetch_req = 1'b0;
        @(negedge clk);
        chk({name, "_valid"}, 32'(fetch_valid), 1);
        chk({name, "_instr"}, fetch_instr, ei);
        chk({name, "_fault"}, 32'(fetch_fault), 32'(ef));
    endtask

    task automatic do_load(input logic [31:0] base, input int nw, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3, input logic exp_err, input string name);
        logic [31:0] d [4];
        d = '{d0, d1, d2, d3};
        @(posedge clk); #1 load_start = 1'b1; load_base = base;
        @(posedge clk); #1 load_start = 1'b0;
        for (int i = 0; i < nw; i++) begin
            load_valid = 1'b1; load_data = d[i]; load_last = (i == nw - 1);
            @(posedge clk); #1;
        end
        load_valid = 1'b0; load_last = 1'b0;
        @(negedge clk);
        chk({name, "_done"}, 32'(load_done), 1);
        chk({name, "_err"}, 32'(load_err), 32'(exp_err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        #1 reset = 1'b1;
        #1 cmp_en = 1'b1;
        chk("rst_busy", 32'(busy), 1);
        chk("rst_valid", 32'(fetch_valid), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        wait_clear("clear_cycles");
        do_fetch(32'h10, NOP, 2'b00, "f_0x10");

        do_load(32'h04, 2, 32'h00948663, 32'h00000033, '0, '0, 1'b0, "ld_04");
        do_fetch(32'h04, 32'h00948663, 2'b00, "f_0x04");
        do_fetch(32'h08, 32'h00000033, 2'b00, "f_0x08");
        do_fetch(32'h06, NOP, 2'b01, "f_mis");
        do_fetch(32'h100, NOP, 2'b10, "f_oor");
        do_fetch(32'h102, NOP, 2'b11, "f_both");

        do_load(32'hF8, 4, 32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 1'b1, "ld_F8");
        do_fetch(32'hF8, 32'hA0000001, 2'b00, "f_w62");
        do_fetch(32'hFC, 32'hA0000002, 2'b00, "f_w63");
        do_fetch(32'h00, NOP, 2'b00, "f_w0");
        do_fetch(32'h04, 32'h00948663, 2'b00, "f_w1_kept");
        do_fetch(32'h0C, NOP, 2'b00, "f_w3");

        // misaligned base with a same-cycle fetch, a fetch during LOAD, and a fetch in the first idle cycle
        @(posedge clk); #1 load_start = 1'b1; load_base = 32'h0A; fetch_req = 1'b1; fetch_addr = 32'h0;
        @(posedge clk); #1 load_start = 1'b0; fetch_req = 1'b0;
        @(negedge clk);
        chk("prio_valid", 32'(fetch_valid), 0);
        chk("prio_ready", 32'(load_ready), 1);
        @(posedge clk); #1 fetch_req = 1'b1; fetch_addr = 32'h08;
        @(posedge clk); #1 fetch_req = 1'b0; load_valid = 1'b1; load_data = 32'hDEADBEEF; load_last = 1'b1;
        @(negedge clk);
        chk("busy_fetch_valid", 32'(fetch_valid), 0);
        @(posedge clk); #1 load_valid = 1'b0; load_last = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h08;
        @(negedge clk);
        chk("mis_done", 32'(load_done), 1);
        chk("mis_err", 32'(load_err), 1);
        @(posedge clk); #1 fetch_req = 1'b0;
        @(negedge clk);
        chk("raw_valid", 32'(fetch_valid), 1);
        chk("raw_instr", fetch_instr, 32'hDEADBEEF);

`ifdef IMEM_PARITY_EN
        parity_flip = 1'b1;
        do_load(32'h00, 1, 32'h00500093, '0, '0, '0, 1'b0, "ld_par");
        parity_flip = 1'b0;
        do_fetch(32'h00, NOP, 3'b100, "f_par");
`endif

        // reset in the middle of a load
        @(posedge clk); #1 load_start = 1'b1; load_base = 32'h00;
        @(posedge clk); #1 load_start = 1'b0; load_valid = 1'b1; load_data = 32'hCAFE0001;
        @(posedge clk); #1 load_data = 32'hCAFE0002;
        @(posedge clk); #1 load_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        #1 chk("midrst_ready", 32'(load_ready), 0);
        chk("midrst_busy", 32'(busy), 1);
        @(posedge clk); #1 reset = 1'b0;
        wait_clear("clear_after_midrst");
        do_fetch(32'h04, NOP, 2'b00, "f_w1_cleared");
        do_fetch(32'h00, NOP, 2'b00, "f_w0_cleared");
        chk("final_err", 32'(load_err), 0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
